// File: rtl/sphere_pkg.sv
// Shared types and helpers for the falling-sphere bank.
package sphere_pkg;

   localparam int FX_WIDTH = 64;
   localparam int FX_FRAC  = 32;

   typedef logic signed [FX_WIDTH-1:0] fixed_real;
   typedef fixed_real [2:0]            vector;
   typedef logic [2:0][7:0]            color;

   typedef enum logic [0:0] {IDLE, SWEEP} sweep_state_e;

   function automatic fixed_real to_fixed(input int v);
      return fixed_real'(v) << FX_FRAC;
   endfunction

   // 64-bit maximal-length Fibonacci LFSR (x^64 + x^63 + x^61 + x^60 + 1)
   function automatic logic [63:0] lfsr_step(input logic [63:0] s);
      return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
   endfunction

endpackage

// File: rtl/sphere_integrator.sv
// One gravity step for a single sphere; shared by the sweep engine.
module sphere_integrator #(
   parameter int               WIDTH     = 64,
   parameter logic [WIDTH-1:0] FLOOR_NEG = '0
) (
   input  logic [2:0][WIDTH-1:0] pos,
   input  logic [2:0][WIDTH-1:0] vel,
   input  logic [WIDTH-1:0]      grav,
   output logic [2:0][WIDTH-1:0] pos_next,
   output logic [2:0][WIDTH-1:0] vel_next,
   output logic                  below_floor
);

   assign vel_next    = {vel[2] - grav, vel[1], vel[0]};
   assign pos_next    = {pos[2] + vel_next[2], pos[1] + vel[1], pos[0] + vel[0]};
   assign below_floor = $signed(pos[2]) < $signed(FLOOR_NEG);

endmodule

// File: rtl/sphere_bank.sv
// Bank of N falling spheres, swept one slot per clock on each frame edge.
// Optional miss counter enabled by defining SPHERE_BANK_MISS_CNT_EN.
module sphere_bank #(
   parameter int          N_SPHERES = 8,
   parameter int          WIDTH     = 64,
   parameter int          FRAC      = 32,
   parameter int          GRAV      = 4,
   parameter int          FLOOR_Z   = 2880,
   parameter int          SPAWN_Z   = 2400,
   parameter int          SPAWN_Y0  = 2840,
   parameter int          SPAWN_DY  = 480,
   parameter int          LAUNCH_VZ = 200,
   parameter int          DIFF_STEP = 2,
   parameter logic [63:0] LFSR_SEED = 64'hACE1_0000_0000_0001,
   localparam int         IW        = $clog2(N_SPHERES)
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Frame_Clk,
   input  logic                  Hit,
   input  logic [IW-1:0]         Hit_index,
   input  logic [IW-1:0]         Read_index,
   output logic [2:0][WIDTH-1:0] Sphere_pos,
   output logic [23:0]           Sphere_col,
   output logic [IW-1:0]         curr_index,
   output logic [N_SPHERES-1:0]  dropped,
   output logic                  busy,
   output logic                  overrun
`ifdef SPHERE_BANK_MISS_CNT_EN
   ,output logic [15:0]          miss_count
`endif
);
   import sphere_pkg::*;

   localparam logic [WIDTH-1:0] GRAV_FX   = WIDTH'(GRAV) << FRAC;
   localparam logic [WIDTH-1:0] FLOOR_NEG = -(WIDTH'(FLOOR_Z) << FRAC);
   localparam logic [WIDTH-1:0] SPAWN_ZFX = -(WIDTH'(SPAWN_Z) << FRAC);
   localparam logic [WIDTH-1:0] LAUNCH_FX = WIDTH'(LAUNCH_VZ) << FRAC;
   localparam logic [IW:0]      NS        = (IW+1)'(N_SPHERES);
   localparam logic [IW-1:0]    LAST      = IW'(N_SPHERES - 1);

   // 16 random bits, sign-extended, with the LSB landing 6 bits below the binary point
   function automatic logic [WIDTH-1:0] rnd_field(input logic [15:0] r);
      return {{(WIDTH-16){r[15]}}, r} << (FRAC - 6);
   endfunction

   function automatic logic [2:0][WIDTH-1:0] spawn_pos(input logic [IW-1:0] i,
         input logic [63:0] l, input logic [WIDTH-1:0] diff);
      spawn_pos[2] = SPAWN_ZFX;
      spawn_pos[1] = ((WIDTH'(SPAWN_Y0) + WIDTH'(SPAWN_DY) * WIDTH'(i)) << FRAC) + diff;
      spawn_pos[0] = rnd_field(l[31:16]);
   endfunction

   function automatic logic [2:0][WIDTH-1:0] spawn_vel(input logic [63:0] l);
      return {LAUNCH_FX, rnd_field(l[47:32]), rnd_field(l[63:48])};
   endfunction

   logic [2:0][WIDTH-1:0] pos_q [N_SPHERES];
   logic [2:0][WIDTH-1:0] vel_q [N_SPHERES];
   color                  col_q [N_SPHERES];

   sweep_state_e          state;
   logic [IW-1:0]         idx;
   logic [63:0]           lfsr;
   logic [WIDTH-1:0]      difficulty;
   logic                  frame_old, frame_pending;
   logic [N_SPHERES-1:0]  hit_pending;

   logic                  frame_edge, hit_ok, hit_now, drop_now, below_floor;
   logic [IW-1:0]         rd_sel;
   logic [2:0][WIDTH-1:0] pos_next, vel_next;

   assign frame_edge = Frame_Clk & ~frame_old;
   assign hit_ok     = Hit && ({1'b0, Hit_index} < NS);
   // A hit landing on the slot being swept this cycle is consumed immediately
   assign hit_now    = hit_pending[idx] | (hit_ok && (Hit_index == idx));
   assign drop_now   = (state == SWEEP) && !hit_now && below_floor;
   assign rd_sel     = ({1'b0, Read_index} < NS) ? Read_index : '0;

   sphere_integrator #(.WIDTH(WIDTH), .FLOOR_NEG(FLOOR_NEG)) u_integrator (
      .pos        (pos_q[idx]),
      .vel        (vel_q[idx]),
      .grav       (GRAV_FX),
      .pos_next   (pos_next),
      .vel_next   (vel_next),
      .below_floor(below_floor)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < N_SPHERES; i++) begin
            pos_q[i] <= spawn_pos(IW'(i), LFSR_SEED, '0);
            vel_q[i] <= spawn_vel(LFSR_SEED);
            col_q[i] <= LFSR_SEED[23:0];
         end
         state         <= IDLE;
         idx           <= '0;
         lfsr          <= LFSR_SEED;
         difficulty    <= '0;
         frame_old     <= 1'b1;
         frame_pending <= 1'b0;
         hit_pending   <= '0;
         dropped       <= '0;
         busy          <= 1'b0;
         overrun       <= 1'b0;
         Sphere_pos    <= '0;
         Sphere_col    <= '0;
         curr_index    <= '0;
      end else begin
         frame_old  <= Frame_Clk;
         lfsr       <= lfsr_step(lfsr);
         dropped    <= '0;
         Sphere_pos <= pos_q[rd_sel];
         Sphere_col <= col_q[rd_sel];
         curr_index <= Read_index;
         if (hit_ok) hit_pending[Hit_index] <= 1'b1;
         case (state)
            IDLE: begin
               if (frame_edge || frame_pending) begin
                  state         <= SWEEP;
                  idx           <= '0;
                  busy          <= 1'b1;
                  frame_pending <= frame_edge & frame_pending;
               end
            end
            SWEEP: begin
               if (frame_edge) begin
                  if (frame_pending) overrun <= 1'b1;
                  else frame_pending <= 1'b1;
               end
               if (hit_now || drop_now) begin
                  pos_q[idx] <= spawn_pos(idx, lfsr, difficulty);
                  vel_q[idx] <= spawn_vel(lfsr);
                  col_q[idx] <= lfsr[23:0];
                  if (hit_now) hit_pending[idx] <= 1'b0;
                  else dropped[idx] <= 1'b1;
               end else begin
                  pos_q[idx] <= pos_next;
                  vel_q[idx] <= vel_next;
               end
               if (idx == LAST) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  difficulty <= difficulty + WIDTH'(DIFF_STEP);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SPHERE_BANK_MISS_CNT_EN
   always_ff @(posedge Clk) begin
      if (Reset) miss_count <= '0;
      else if (drop_now && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
   end
`endif

endmodule

// File: doc/sphere_bank.md
Name: sphere_bank

Overview:
- Parametrised successor to the fixed four-sphere register: holds N falling target spheres (position, velocity, colour) in fixed-point.
- Once per frame, a sequential engine advances each sphere's kinematics under gravity, one slot per clock.
- Respawns spheres that are hit or that fall below the floor.
- Serves a registered random-access read port to the ray/render pipeline.

Parameters:
- N_SPHERES, 8, number of sphere slots (2..64, power of two not required)
- WIDTH, 64, bits per fixed-point component (two's complement)
- FRAC, 32, fractional bits within WIDTH
- GRAV, 4, integer gravity magnitude subtracted from vertical velocity per frame
- FLOOR_Z, 2880, integer magnitude of drop threshold (drop when z < -FLOOR_Z)
- SPAWN_Z, 2400, integer magnitude of spawn height (spawn z = -SPAWN_Z)
- SPAWN_Y0, 2840, integer depth of slot 0 spawn
- SPAWN_DY, 480, integer depth increment per slot
- LAUNCH_VZ, 200, integer initial vertical velocity
- DIFF_STEP, 2, raw LSB increment of difficulty per frame
- LFSR_SEED, 64'hACE1_0000_0000_0001, nonzero LFSR reset value

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous active-high reset
- Frame_Clk  in  1  frame strobe level; rising edge (sampled on Clk) starts an update sweep
- Hit  in  1  single-cycle hit pulse
- Hit_index  in  $clog2(N_SPHERES)  slot that was hit
- Read_index  in  $clog2(N_SPHERES)  read slot
- Sphere_pos  out  3*WIDTH  position of Read_index, component 2 vertical, component 1 depth, component 0 lateral
- Sphere_col  out  24  RGB of Read_index
- curr_index  out  $clog2(N_SPHERES)  index matching Sphere_pos/Sphere_col
- dropped  out  N_SPHERES  one-cycle pulse per slot that fell below floor
- busy  out  1  high while sweep in progress
- overrun  out  1  sticky; a frame edge arrived while one was already pending

Behaviour:
- One clock, synchronous active-high reset. Reset dominates all other inputs, including mid-sweep.
- Reset state:
  - every slot loaded with its spawn value (difficulty=0); colours from LFSR_SEED-derived bits
  - LFSR=LFSR_SEED, FSM=IDLE, busy=0, overrun=0, dropped=0, hit_pending=0, frame_pending=0
  - Sphere_pos=0, Sphere_col=0, curr_index=0
- Frame edge: Frame_Clk registered once; edge = ~old & Frame_Clk. Old resets to 1.
- FSM states IDLE, SWEEP.
  - IDLE -> SWEEP on edge or frame_pending; clears frame_pending, idx=0, busy=1.
  - SWEEP processes slot idx each cycle; idx increments. After idx=N_SPHERES-1 -> IDLE, busy=0, difficulty += DIFF_STEP.
  - Sweep length is exactly N_SPHERES cycles.
- Edge during SWEEP: sets frame_pending. If frame_pending is already set: overrun<=1, edge dropped.
- Per-slot update, in priority order:
  1. hit_pending[idx]: respawn, clear bit, no drop pulse.
  2. Else, old z negative and |z| > FLOOR_Z<<FRAC: respawn, dropped[idx]=1 for that cycle.
  3. Else: vel' = vel + {-GRAV<<FRAC, 0, 0}; pos' = pos + vel'.
  - All adds are modulo 2^WIDTH; no saturation.
- Respawn values:
  - pos = {-(SPAWN_Z<<FRAC), ((SPAWN_Y0 + idx*SPAWN_DY)<<FRAC) + difficulty, lateral}, where lateral = sign-extended 16 LFSR bits placed at bits [FRAC+9:FRAC-6]
  - vel = {LAUNCH_VZ<<FRAC, r1, r0}; r1 and r0 use the same 16-bit field format from independent LFSR taps
  - col = LFSR[23:0]
  - LFSR advances one step every Clk; lfsr_step is shared.
- Hit: sets hit_pending[Hit_index] in any state; it is consumed at that slot's next sweep slot. A hit and a sweep slot coinciding on the same index in the same cycle is consumed in that cycle. Hit_index >= N_SPHERES is ignored.
- Read port:
  - 1-cycle latency: Sphere_pos/Sphere_col/curr_index <= slot[Read_index] as committed at the clock edge.
  - A read of the slot being written this cycle returns the pre-update value.
  - Read_index >= N_SPHERES returns slot 0 data with curr_index echoed.

Optional Feature:
- Macro SPHERE_BANK_MISS_CNT_EN.
- Defined: adds output miss_count (16 bits), a count of dropped pulses, saturating at 16'hFFFF, cleared by Reset. If several slots drop in one cycle, each is counted; the sweep guarantees at most one per cycle.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package sphere_pkg:
  - typedefs fixed_real (WIDTH), vector ([2:0] fixed_real), color ([2:0][7:0])
  - FSM enum
  - function to_fixed(int) returning int<<FRAC
- Sub-module sphere_integrator (combinational): pos, vel, grav -> pos', vel', below_floor. Instantiated once and shared by the sweep, replacing per-slot adders.

Test Plan:
- Reset, then read slot 3 -> after 1 cycle, Sphere_pos[2] = -(2400<<32), Sphere_pos[1] = (2840+3*480)<<32, curr_index=3.
- One Frame_Clk edge with N=8 -> busy high 8 cycles. Slot 0 gets vel[2]=196<<32 and pos[2]=-(2204<<32). Difficulty reads 2 at next spawn.
- Hit=1, Hit_index=5 while idle, then frame edge -> slot 5 respawned at sweep slot 5 cycle, dropped[5]=0, other slots integrate.
- Force slot 2 z=-(2881<<32) via repeated frames -> dropped[2] pulses exactly one cycle, slot 2 back to spawn z. Same case with a simultaneous hit on slot 2 -> no pulse.
- Two frame edges inside one sweep -> second sweep follows immediately, overrun=1 after third edge. Reset mid-sweep -> busy=0 next cycle, all slots at spawn.
- With SPHERE_BANK_MISS_CNT_EN, 3 drops -> miss_count=3. Preload 16'hFFFF plus one drop -> stays 16'hFFFF.
